// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes,
// AXI response codes, bus widths and the alignment check.
package ysyx_25020037_lsu_pkg;

  localparam int PASS_WD         = 96;
  localparam int LU_TO_WU_BUS_WD = PASS_WD + 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_AR,
    S_RD_R,
    S_WR_AWW,
    S_WR_B,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // op[1] marks a word access, op[0] a halfword; bytes never fault
  function automatic logic misaligned(input logic [2:0] op,
                                      input logic [1:0] lo);
    if (op[1])
      return lo != 2'b00;
    else if (op[0])
      return lo[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load lane
// selection with sign or zero extension.
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ldata
);

  logic [31:0] rsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    rsh    = rdata >> {lo, 3'b000};
    byte_v = rsh[7:0];
    half_v = lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (op)
      OP_B:    ldata = {{24{byte_v[7]}}, byte_v};
      OP_BU:   ldata = {24'h0, byte_v};
      OP_H:    ldata = {{16{half_v[15]}}, half_v};
      OP_HU:   ldata = {16'h0, half_v};
      default: ldata = rdata;
    endcase
  end

  always_comb begin
    if (op[1]) begin
      wstrb      = 4'b1111;
      lane_wdata = wdata;
    end else if (op[0]) begin
      wstrb      = 4'b0011 << {lo[1], 1'b0};
      lane_wdata = {16'h0, wdata[15:0]} << {lo[1], 4'b0000};
    end else begin
      wstrb      = 4'b0001 << lo;
      lane_wdata = {24'h0, wdata[7:0]} << {lo, 3'b000};
    end
  end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit between EXU and WBU: one AXI4-Lite data access per
// instruction, one-cycle lsu_valid pulse with a held result bus.
module ysyx_25020037_lsu
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int PASS_WD = ysyx_25020037_lsu_pkg::PASS_WD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exu_valid,
  output logic                 lsu_ready,
  input  logic [PASS_WD-1:0]   pass_bus,
  input  logic                 mem_ren,
  input  logic                 mem_wen,
  input  logic [2:0]           mem_op,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 lsu_valid,
  output logic                 lsu_fault,
  output logic [PASS_WD+63:0]  lu_to_wu_bus,
  output logic [31:0]          m_araddr,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [31:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic [31:0]          m_awaddr,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready
);

  state_t             state;
  logic [2:0]         op_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [PASS_WD-1:0] pass_q;
  logic               fault_q;
  logic [31:0]        ldata;

  ysyx_25020037_lsu_align u_align (
    .op         (op_q),
    .lo         (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (m_rdata),
    .lane_wdata (m_wdata),
    .wstrb      (m_wstrb),
    .ldata      (ldata)
  );

  // address/data are driven from captured regs, so stable while valid
  assign m_araddr  = {addr_q[31:2], 2'b00};
  assign m_awaddr  = addr_q;
  assign lsu_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      pass_q       <= '0;
      fault_q      <= 1'b0;
      m_arvalid    <= 1'b0;
      m_rready     <= 1'b0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_bready     <= 1'b0;
      lsu_valid    <= 1'b0;
      lsu_fault    <= 1'b0;
      lu_to_wu_bus <= '0;
    end else begin
      lsu_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (exu_valid) begin
          op_q    <= mem_op;
          addr_q  <= addr;
          wdata_q <= wdata;
          pass_q  <= pass_bus;
          rdata_q <= '0;
          fault_q <= 1'b0;
          if ((mem_ren || mem_wen) && misaligned(mem_op, addr[1:0])) begin
            fault_q <= 1'b1;
            state   <= S_DONE;
          end else if (mem_ren) begin
            m_arvalid <= 1'b1;
            state     <= S_RD_AR;
          end else if (mem_wen) begin
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            state     <= S_WR_AWW;
          end else begin
            state <= S_DONE;
          end
        end
        S_RD_AR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          state     <= S_RD_R;
        end
        S_RD_R: if (m_rvalid) begin
          m_rready <= 1'b0;
          rdata_q  <= ldata;
          fault_q  <= m_rresp != RESP_OKAY;
          state    <= S_DONE;
        end
        S_WR_AWW: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= S_WR_B;
          end
        end
        S_WR_B: if (m_bvalid) begin
          m_bready <= 1'b0;
          fault_q  <= m_bresp != RESP_OKAY;
          state    <= S_DONE;
        end
        S_DONE: begin
          lsu_valid    <= 1'b1;
          lsu_fault    <= fault_q;
          lu_to_wu_bus <= {pass_q, addr_q, rdata_q};
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Directed bench for the load/store unit with a small AXI4-Lite
// slave model whose ready/valid timing can be throttled.
module tb_ysyx_25020037_lsu;

  logic         clk;
  logic         rst;
  logic         exu_valid;
  logic         lsu_ready;
  logic [95:0]  pass_bus;
  logic         mem_ren, mem_wen;
  logic [2:0]   mem_op;
  logic [31:0]  addr, wdata;
  logic         lsu_valid, lsu_fault;
  logic [159:0] lu_to_wu_bus;
  logic [31:0]  m_araddr, m_rdata, m_awaddr, m_wdata;
  logic         m_arvalid, m_rvalid, m_rready;
  logic         m_awvalid, m_wvalid, m_bvalid, m_bready;
  logic [1:0]   m_rresp, m_bresp;
  logic [3:0]   m_wstrb;

  logic s_arready, s_awready, s_wready, s_rhold;
  logic r_pend, aw_got, w_got;
  int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, v_cnt = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  int tests = 0;
  int fails = 0;

  ysyx_25020037_lsu dut (
    .clk (clk), .rst (rst),
    .exu_valid (exu_valid), .lsu_ready (lsu_ready),
    .pass_bus (pass_bus),
    .mem_ren (mem_ren), .mem_wen (mem_wen), .mem_op (mem_op),
    .addr (addr), .wdata (wdata),
    .lsu_valid (lsu_valid), .lsu_fault (lsu_fault),
    .lu_to_wu_bus (lu_to_wu_bus),
    .m_araddr (m_araddr), .m_arvalid (m_arvalid), .m_arready (s_arready),
    .m_rdata (m_rdata), .m_rresp (m_rresp),
    .m_rvalid (m_rvalid), .m_rready (m_rready),
    .m_awaddr (m_awaddr), .m_awvalid (m_awvalid), .m_awready (s_awready),
    .m_wdata (m_wdata), .m_wstrb (m_wstrb),
    .m_wvalid (m_wvalid), .m_wready (s_wready),
    .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_rvalid = r_pend && !s_rhold;

  // slave: R follows AR, B follows completion of both AW and W
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      m_bvalid <= 1'b0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      if (m_arvalid && s_arready) begin
        ar_cnt      <= ar_cnt + 1;
        last_araddr <= m_araddr;
        r_pend      <= 1'b1;
      end
      if (m_rvalid && m_rready) r_pend <= 1'b0;
      if (m_awvalid && s_awready) begin
        aw_cnt      <= aw_cnt + 1;
        last_awaddr <= m_awaddr;
      end
      if (m_wvalid && s_wready) begin
        w_cnt      <= w_cnt + 1;
        last_wdata <= m_wdata;
        last_wstrb <= m_wstrb;
      end
      if (((m_awvalid && s_awready) || aw_got) &&
          ((m_wvalid && s_wready) || w_got)) begin
        m_bvalid <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (m_awvalid && s_awready) aw_got <= 1'b1;
        if (m_wvalid && s_wready)   w_got  <= 1'b1;
      end
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        b_cnt    <= b_cnt + 1;
      end
      if (lsu_valid) v_cnt <= v_cnt + 1;
    end
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] res;
    logic        fault;
    int          lat;
    int          nar;
    int          naw;
    logic [3:0]  strb;
    logic [31:0] lane;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic ren, input logic wen, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [95:0] p);
    @(negedge clk);
    mem_ren = ren; mem_wen = wen; mem_op = op;
    addr = a; wdata = d; pass_bus = p;
    exu_valid = 1'b1;
    @(posedge clk);
    #1 exu_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!lsu_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!lsu_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no lsu_valid expected a pulse", name);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int ar0, aw0, lat;
    logic [95:0] p;
    string n;
    v = vt[i];
    n = $sformatf("v%0d", i);
    p = {32'(i), ~32'(i), 32'hC0DE_0000 | 32'(i)};
    ar0 = ar_cnt; aw0 = aw_cnt;
    m_rdata = v.rdata; m_rresp = v.resp; m_bresp = v.resp;
    pulse(v.ren, v.wen, v.op, v.addr, v.wdata, p);
    wait_valid(n, lat);
    chk({n, "_lat"}, 160'(lat), 160'(v.lat));
    chk({n, "_fault"}, 160'(lsu_fault), 160'(v.fault));
    chk({n, "_bus"}, lu_to_wu_bus, {p, v.addr, v.res});
    chk({n, "_nar"}, 160'(ar_cnt - ar0), 160'(v.nar));
    chk({n, "_naw"}, 160'(aw_cnt - aw0), 160'(v.naw));
    if (v.nar != 0)
      chk({n, "_araddr"}, 160'(last_araddr), 160'(v.addr & 32'hFFFF_FFFC));
    if (v.naw != 0) begin
      chk({n, "_awaddr"}, 160'(last_awaddr), 160'(v.addr));
      chk({n, "_wstrb"}, 160'(last_wstrb), 160'(v.strb));
      chk({n, "_wdata"}, 160'(last_wdata), 160'(v.lane));
    end
    @(posedge clk);
    #1;
    chk({n, "_pulse1"}, 160'(lsu_valid), 160'(0));
    chk({n, "_ready"}, 160'(lsu_ready), 160'(1));
  endtask

  // one address channel accepted first, the other three cycles later
  task automatic split_store(input logic aw_first);
    int b0, v0, aw0, w0, lat;
    string n;
    n = aw_first ? "aw_first" : "w_first";
    b0 = b_cnt; v0 = v_cnt; aw0 = aw_cnt; w0 = w_cnt;
    s_awready = aw_first;
    s_wready  = !aw_first;
    m_bresp   = 2'b00;
    pulse(1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'h1122_3344, 96'h5);
    @(posedge clk);
    #1;
    chk({n, "_awvalid"}, 160'(m_awvalid), 160'(!aw_first));
    chk({n, "_wvalid"}, 160'(m_wvalid), 160'(aw_first));
    pulse(1'b0, 1'b0, 3'b000, 32'hDEAD_0000, 32'h0, 96'h7);
    @(posedge clk);
    #1;
    chk({n, "_held"}, 160'({m_awvalid, m_wvalid}),
        160'({!aw_first, aw_first}));
    @(negedge clk);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    wait_valid(n, lat);
    chk({n, "_fault"}, 160'(lsu_fault), 160'(0));
    chk({n, "_bus"}, lu_to_wu_bus, {96'h5, 32'h8000_0020, 32'h0});
    repeat (3) @(posedge clk);
    #1;
    chk({n, "_nb"}, 160'(b_cnt - b0), 160'(1));
    chk({n, "_nvalid"}, 160'(v_cnt - v0), 160'(1));
    chk({n, "_naw_nw"}, 160'({aw_cnt - aw0, w_cnt - w0}), 160'({32'd1, 32'd1}));
  endtask

  initial begin
    vt[0]  = '{0, 0, 3'b010, 32'h1234_5678, 0, 0, 0, 32'h0, 0, 2, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 0, 4, 1, 0, 0, 0};
    vt[2]  = '{1, 0, 3'b100, 32'h8000_0003, 0, 32'h80FF_1234, 0, 32'h0000_0080, 0, 4, 1, 0, 0, 0};
    vt[3]  = '{1, 0, 3'b001, 32'h8000_0002, 0, 32'h80FF_1234, 0, 32'hFFFF_80FF, 0, 4, 1, 0, 0, 0};
    vt[4]  = '{1, 0, 3'b101, 32'h8000_0000, 0, 32'h80FF_1234, 0, 32'h0000_1234, 0, 4, 1, 0, 0, 0};
    vt[5]  = '{1, 0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 4, 1, 0, 0, 0};
    vt[6]  = '{1, 0, 3'b000, 32'h8000_0001, 0, 32'h80FF_1234, 0, 32'h0000_0012, 0, 4, 1, 0, 0, 0};
    vt[7]  = '{0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 0, 0, 0, 4, 0, 1, 4'b1100, 32'hBEEF_0000};
    vt[8]  = '{0, 1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0, 0, 0, 0, 4, 0, 1, 4'b0010, 32'h0000_AB00};
    vt[9]  = '{0, 1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 0, 0, 0, 4, 0, 1, 4'b1111, 32'hCAFE_F00D};
    vt[10] = '{1, 0, 3'b010, 32'h8000_0001, 0, 32'h5555_5555, 0, 32'h0, 1, 2, 0, 0, 0, 0};
    vt[11] = '{1, 0, 3'b010, 32'h8000_000C, 0, 32'h1122_3344, 2'b10, 32'h1122_3344, 1, 4, 1, 0, 0, 0};
    vt[12] = '{0, 1, 3'b001, 32'h8000_0003, 32'h1, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    vt[13] = '{0, 1, 3'b010, 32'h8000_0010, 32'h0BAD_F00D, 0, 2'b10, 0, 1, 4, 0, 1, 4'b1111, 32'h0BAD_F00D};
    vt[14] = '{1, 0, 3'b101, 32'h8000_0003, 0, 32'h80FF_1234, 0, 32'h0, 1, 2, 0, 0, 0, 0};
    vt[15] = '{0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0, 0, 4, 0, 1, 4'b1000, 32'hA500_0000};

    rst = 1'b1;
    exu_valid = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_op = 3'b000;
    addr = '0; wdata = '0; pass_bus = '0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_rhold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", 160'({lsu_valid, lsu_fault, m_arvalid, m_rready,
                            m_awvalid, m_wvalid, m_bready}), 160'(0));
    chk("rst_bus", lu_to_wu_bus, 160'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 160'(lsu_ready), 160'(1));

    for (int i = 0; i < 16; i++) run_vec(i);

    split_store(1'b1);
    split_store(1'b0);

    // reset while the read data phase is outstanding
    s_rhold = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    pulse(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0, 96'h9);
    @(posedge clk);
    #1;
    chk("midrst_in_rd_r", 160'({m_arvalid, m_rready}), 160'(2'b01));
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 160'({m_arvalid, m_rready, lsu_valid, lsu_ready}),
        160'(0));
    @(negedge clk);
    rst = 1'b0;
    s_rhold = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", 160'({lsu_ready, lsu_valid}), 160'(2'b10));
    run_vec(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
